// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for three requesters sharing one 3-to-1 mux-selected resource.
// It issues a registered one-hot grant with a bounded hold and forces rotation under contention.
module mux3_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  output logic [2:0] grant_o,
  output logic [1:0] select_o,
  output logic       valid_o,
  output logic       preempt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q, preempt_d;

  logic [1:0]       holder;
  logic [2:0]       others;
  logic [1:0]       pick_idle;
  logic [1:0]       pick_next;
  logic             hold_expired;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First set bit of vec, scanning start, start+1, start+2 (mod 3).
  function automatic logic [1:0] scan3(input logic [1:0] start, input logic [2:0] vec);
    logic [1:0] i0, i1, i2;
    i0 = start;
    i1 = inc3(i0);
    i2 = inc3(i1);
    if (vec[i0])      scan3 = i0;
    else if (vec[i1]) scan3 = i1;
    else              scan3 = i2;
  endfunction

  function automatic logic [1:0] enc3(input logic [2:0] oh);
    case (oh)
      3'b010:  enc3 = 2'b01;
      3'b100:  enc3 = 2'b10;
      default: enc3 = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] dec3(input logic [1:0] idx);
    dec3 = 3'b001 << idx;
  endfunction

  assign holder       = enc3(grant_q);
  assign others       = req_i & ~grant_q;
  assign pick_idle    = scan3(ptr_q, req_i);
  assign pick_next    = scan3(inc3(holder), others);
  assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= 3'b000;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_i != 3'b000) begin
          state_d = ST_GRANT;
          grant_d = dec3(pick_idle);
          ptr_d   = inc3(pick_idle);
          cnt_d   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!req_i[holder]) begin
          if (others != 3'b000) begin
            grant_d = dec3(pick_next);
            ptr_d   = inc3(pick_next);
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            cnt_d   = '0;
          end
        end else if (hold_expired && (others != 3'b000)) begin
          // Forced rotation: the holder still wants the resource but someone is waiting.
          grant_d   = dec3(pick_next);
          ptr_d     = inc3(pick_next);
          cnt_d     = CNT_W'(1);
          preempt_d = 1'b1;
        end else if (!hold_expired) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        cnt_d   = '0;
      end
    endcase
  end

  assign grant_o   = grant_q;
  assign select_o  = enc3(grant_q);
  assign valid_o   = |grant_q;
  assign preempt_o = preempt_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: rotation, hold, handoff, idle, async reset, MAX_HOLD=1.
module tb_mux3_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [2:0] req_i = 3'b000;
  logic [2:0] grant_o;
  logic [1:0] select_o;
  logic       valid_o;
  logic       preempt_o;

  logic [2:0] req1 = 3'b000;
  logic [2:0] grant1;
  logic [1:0] select1;
  logic       valid1;
  logic       preempt1;

  int n_chk  = 0;
  int n_pass = 0;

  mux3_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i),
    .grant_o(grant_o), .select_o(select_o), .valid_o(valid_o), .preempt_o(preempt_o)
  );

  mux3_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req1),
    .grant_o(grant1), .select_o(select1), .valid_o(valid1), .preempt_o(preempt1)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b010:  sel_of = 2'b01;
      3'b100:  sel_of = 2'b10;
      default: sel_of = 2'b00;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic [2:0] g, input logic p);
    check({tag, " grant"}, grant_o, g);
    check({tag, " select"}, select_o, sel_of(g));
    check({tag, " valid"}, valid_o, (g != 3'b000));
    check({tag, " preempt"}, preempt_o, p);
    check({tag, " sel!=11"}, (select_o == 2'b11), 0);
  endtask

  logic [2:0] exp_rot [13];
  logic       exp_pre [13];
  logic [2:0] exp_rot1 [6];

  initial begin
    exp_rot = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
                3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    exp_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rot1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // Reset state
    tick(); tick();
    check_all("reset", 3'b000, 1'b0);
    check("reset dut1 grant", grant1, 0);

    // Full contention, MAX_HOLD=4 and MAX_HOLD=1 side by side
    rst_i = 1'b1;
    req_i = 3'b111;
    req1  = 3'b111;
    for (int i = 0; i < 13; i++) begin
      tick();
      check_all($sformatf("rot c%0d", i + 1), exp_rot[i], exp_pre[i]);
      if (i < 6) begin
        check($sformatf("mh1 grant c%0d", i + 1), grant1, exp_rot1[i]);
        check($sformatf("mh1 preempt c%0d", i + 1), preempt1, (i != 0));
        check($sformatf("mh1 select c%0d", i + 1), select1, sel_of(exp_rot1[i]));
      end
    end
    req1 = 3'b000;

    // Single requester holds indefinitely, no preemption
    req_i = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all($sformatf("solo c%0d", i + 1), 3'b010, 1'b0);
    end

    // All requests drop -> idle (ptr now 2)
    req_i = 3'b000;
    tick();
    check_all("drop", 3'b000, 1'b0);
    check("drop dut1 valid", valid1, 0);

    // Direct handoff 0 -> 2 on release, no idle gap
    req_i = 3'b001;
    tick();
    check_all("h0", 3'b001, 1'b0);
    req_i = 3'b101;
    tick();
    check_all("h0 held", 3'b001, 1'b0);
    req_i = 3'b100;
    tick();
    check_all("handoff 2", 3'b100, 1'b0);

    // Grant to 2 ends, idle, then 011 -> 0 (ptr=0), release -> 1
    req_i = 3'b000;
    tick();
    check_all("idle", 3'b000, 1'b0);
    req_i = 3'b011;
    tick();
    check_all("ptr0", 3'b001, 1'b0);
    req_i = 3'b010;
    tick();
    check_all("rel to 1", 3'b010, 1'b0);

    // Asynchronous reset mid-grant
    req_i = 3'b111;
    #2 rst_i = 1'b0;
    #1;
    check("async grant", grant_o, 0);
    check("async valid", valid_o, 0);
    check("async select", select_o, 0);
    @(negedge clk_i);
    check_all("in reset", 3'b000, 1'b0);
    rst_i = 1'b1;
    tick();
    check_all("post reset", 3'b001, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
